// File: rtl/spart_tx_arbiter.sv
// Round-robin arbiter sharing one SPART transmit path among NUM_REQ requesters.
// It grants one byte at a time, pulses trmt/ack together, and tracks TBR until the frame completes.
module spart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int IDX_W        = 2,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      trmt,
  input  logic                      TBR,
  output logic                      busy,
  output logic [IDX_W-1:0]          owner,
  output logic                      err
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t              state, state_n;
  logic [IDX_W-1:0]    ptr, ptr_n, owner_n;
  logic                lock_vld, lock_n, err_n, trmt_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [DATA_W-1:0]   tx_data_n;
  logic [NUM_REQ-1:0]  ack_n;

  logic                rr_vld;
  logic [IDX_W-1:0]    rr_idx, cand, win;
  logic                lock_hit;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(NUM_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  // First requesting index at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    rr_vld = 1'b0;
    rr_idx = '0;
    cand   = ptr;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!rr_vld && req[cand]) begin
        rr_vld = 1'b1;
        rr_idx = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  assign lock_hit = lock_vld && req[owner];
  assign win      = lock_hit ? owner : rr_idx;

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    owner_n   = owner;
    lock_n    = lock_vld;
    err_n     = err;
    cnt_n     = cnt;
    tx_data_n = tx_data;
    trmt_n    = 1'b0;
    ack_n     = '0;
    unique case (state)
      IDLE: begin
        // An owner that stops requesting gives up its lock without stalling others.
        if (lock_vld && !req[owner]) lock_n = 1'b0;
        if (TBR && rr_vld) begin
          tx_data_n = req_data[int'(win)*DATA_W +: DATA_W];
          trmt_n    = 1'b1;
          ack_n     = NUM_REQ'(1) << win;
          owner_n   = win;
          lock_n    = req_lock[win];
          cnt_n     = '0;
          state_n   = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!TBR) begin
          state_n = WAIT_DONE;
        end else begin
          cnt_n = cnt + 1'b1;
          if (cnt_n == CNT_W'(BUSY_TIMEOUT)) begin
            err_n   = 1'b1;
            state_n = IDLE;
            ptr_n   = wrap_inc(owner);
          end
        end
      end
      WAIT_DONE: begin
        if (TBR) begin
          state_n = IDLE;
          if (!lock_vld) ptr_n = wrap_inc(owner);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      lock_vld <= 1'b0;
      err      <= 1'b0;
      cnt      <= '0;
      tx_data  <= '0;
      trmt     <= 1'b0;
      ack      <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      owner    <= owner_n;
      lock_vld <= lock_n;
      err      <= err_n;
      cnt      <= cnt_n;
      tx_data  <= tx_data_n;
      trmt     <= trmt_n;
      ack      <= ack_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_spart_tx_arbiter.sv
// Scoreboard bench for spart_tx_arbiter: directed requester/transmitter stimulus,
// expected grants queued up front and checked by an independent monitor.
module tb_spart_tx_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int FRAME = 10;

  logic         clk, rst_n;
  logic [N-1:0] req, req_lock, ack;
  logic [N*W-1:0] req_data;
  logic [W-1:0] tx_data;
  logic         trmt, TBR, busy, err;
  logic [1:0]   owner;

  spart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .IDX_W(2), .BUSY_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_lock(req_lock), .req_data(req_data),
    .ack(ack), .tx_data(tx_data), .trmt(trmt), .TBR(TBR), .busy(busy),
    .owner(owner), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] ack;
    logic [7:0] data;
    logic [1:0] owner;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  int       rem[N];
  int       lock_left[N];
  logic [7:0] data_tab[N];
  int       tx_cnt;
  logic     block, stuck;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic void push(input logic [3:0] a, input logic [7:0] d, input logic [1:0] o);
    exp_t e;
    e.ack = a; e.data = d; e.owner = o;
    sb.push_back(e);
  endfunction

  function automatic void apply_tbr();
    TBR = (tx_cnt == 0) && !block;
  endfunction

  // One clock of the requester and transmitter models, applied just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (trmt && !stuck) tx_cnt = FRAME;
    else if (tx_cnt > 0) tx_cnt--;
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        req[i] = 1'b0;
        rem[i]--;
        if (lock_left[i] > 0) lock_left[i]--;
        data_tab[i] = data_tab[i] + 8'd1;
      end else if (rem[i] > 0) begin
        req[i] = 1'b1;
      end
      req_lock[i] = (lock_left[i] > 0);
      req_data[i*W +: W] = data_tab[i];
    end
    apply_tbr();
  endtask

  task automatic wait_grant(input string name);
    logic got;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      step();
      if (trmt) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s grant_wait actual=none required=trmt within 40 cycles", name);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 60) begin
      step();
      n++;
    end
  endtask

  // Monitor: every trmt/ack presentation must match the next queued grant.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (trmt || ack != '0) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_grant actual ack=%0h trmt=%0b required=no grant", ack, trmt);
        end else begin
          e = sb.pop_front();
          check("mon_trmt", 32'(trmt), 32'd1);
          check("mon_ack", 32'(ack), 32'(e.ack));
          check("mon_tx_data", 32'(tx_data), 32'(e.data));
          check("mon_owner", 32'(owner), 32'(e.owner));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    logic seen;
    rst_n = 1'b0; block = 1'b0; stuck = 1'b0; tx_cnt = 0;
    req = '0; req_lock = '0; req_data = '0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; lock_left[i] = 0; data_tab[i] = '0;
    end
    apply_tbr();
    repeat (3) @(posedge clk);
    #1;
    check("rst_trmt", 32'(trmt), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    step();

    // Single request from 2; one-cycle latency, busy while TBR is low.
    data_tab[2] = 8'hA5; rem[2] = 1;
    push(4'b0100, 8'hA5, 2'd2);
    step();
    step();
    check("single_latency_trmt", 32'(trmt), 1);
    wait_idle(n);
    check("single_busy_cycles", n, 11);
    check("single_tx_data_hold", 32'(tx_data), 32'hA5);
    check("single_owner", 32'(owner), 2);

    // Reset in WAIT_DONE, then ptr=0 search wraps to requester 3.
    data_tab[0] = 8'h21; rem[0] = 1;
    push(4'b0001, 8'h21, 2'd0);
    wait_grant("pre_reset");
    repeat (3) step();
    check("pre_reset_busy", 32'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_trmt_ack", {31'(ack), trmt}, 0);
    check("midrst_tx_data", 32'(tx_data), 0);
    check("midrst_owner_err", {owner, err}, 0);
    tx_cnt = 0; apply_tbr();
    step();
    rst_n = 1'b1;
    data_tab[3] = 8'h3C; rem[3] = 1;
    push(4'b1000, 8'h3C, 2'd3);
    wait_grant("post_reset");
    wait_idle(n);
    check("post_reset_owner", 32'(owner), 3);

    // Round robin with all four requesting: 0,1,2,3,0.
    data_tab[0] = 8'h40; data_tab[1] = 8'h50; data_tab[2] = 8'h60; data_tab[3] = 8'h70;
    rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
    push(4'b0001, 8'h40, 2'd0);
    push(4'b0010, 8'h50, 2'd1);
    push(4'b0100, 8'h60, 2'd2);
    push(4'b1000, 8'h70, 2'd3);
    push(4'b0001, 8'h41, 2'd0);
    for (int f = 0; f < 5; f++) begin
      wait_grant("rr");
      wait_idle(n);
    end

    // Lock: requester 1 keeps ownership for three bytes, then 0 is served.
    data_tab[1] = 8'h80; rem[1] = 3; lock_left[1] = 2;
    data_tab[0] = 8'h90; rem[0] = 1;
    push(4'b0010, 8'h80, 2'd1);
    push(4'b0010, 8'h81, 2'd1);
    push(4'b0010, 8'h82, 2'd1);
    push(4'b0001, 8'h90, 2'd0);
    for (int f = 0; f < 4; f++) begin
      wait_grant("lock");
      wait_idle(n);
    end

    // TBR low in IDLE blocks the grant until it rises.
    block = 1'b1; apply_tbr();
    data_tab[0] = 8'hC3; rem[0] = 1;
    push(4'b0001, 8'hC3, 2'd0);
    seen = 1'b0;
    repeat (6) begin
      step();
      if (trmt) seen = 1'b1;
    end
    check("blocked_no_trmt", 32'(seen), 0);
    block = 1'b0; apply_tbr();
    step();
    check("blocked_release_trmt", 32'(trmt), 1);
    wait_idle(n);

    // TBR never falls: err after four WAIT_BUSY cycles, then normal service.
    stuck = 1'b1;
    data_tab[2] = 8'hE7; rem[2] = 1;
    push(4'b0100, 8'hE7, 2'd2);
    wait_grant("timeout");
    check("timeout_err_early", 32'(err), 0);
    repeat (3) step();
    check("timeout_pre_busy_err", {busy, err}, 32'b10);
    step();
    check("timeout_err_set", 32'(err), 1);
    check("timeout_busy_clear", 32'(busy), 0);
    stuck = 1'b0;
    data_tab[3] = 8'h5A; rem[3] = 1;
    push(4'b1000, 8'h5A, 2'd3);
    wait_grant("after_timeout");
    wait_idle(n);
    check("err_sticky", 32'(err), 1);

    repeat (3) step();
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
